// File: rtl/shift_arb_pkg.sv
// Shared types for the shift arbiter: bf16 operand layout,
// FSM states and the buffered result entry.
package shift_arb_pkg;

    localparam int ID_W = 8;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } bf16_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        bf16_t           data;
        logic [ID_W-1:0] id;
        logic            last;
    } res_entry_t;

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr,
// returned both one-hot and as an index.
module rr_arbiter
    import shift_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    int j;

    // Rotating priority search starting at ptr
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (grant == '0 && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rshift.sv
// bf16 scale by 2^-shift: exponent arithmetic only.
// Zero/denormal flush to signed zero, inf/nan pass, overflow -> inf.
module rshift
    import shift_arb_pkg::*;
(
    input  bf16_t             a,
    input  logic signed [7:0] shift,
    output bf16_t             y
);

    logic signed [9:0] e;

    // Adjust exponent and saturate at both ends
    always_comb begin
        y = a;
        e = $signed({2'b00, a.exp}) - $signed({{2{shift[7]}}, shift});
        if (a.exp == 8'h00) begin
            y = '{sign: a.sign, exp: 8'h00, man: 7'h00};
        end else if (a.exp == 8'hFF) begin
            y = a;
        end else if (e <= 0) begin
            y = '{sign: a.sign, exp: 8'h00, man: 7'h00};
        end else if (e >= 255) begin
            y = '{sign: a.sign, exp: 8'hFF, man: 7'h00};
        end else begin
            y.exp = e[7:0];
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Burst-locked round-robin arbiter over one shared bf16 rshift unit.
// Optional SHIFT_ARBITER_PERF_EN adds transfer/stall counters.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int FIFO_DEPTH = 2,
    localparam int IW         = idx_w(NUM_REQ),
    localparam int AW         = idx_w(FIFO_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][15:0] req_data,
    input  logic [NUM_REQ-1:0][7:0]  req_shift,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_data,
    output logic [IW-1:0]            res_id,
    output logic                     res_last,
    output logic                     busy
`ifdef SHIFT_ARBITER_PERF_EN
    ,
    output logic [31:0]              perf_elems,
    output logic [31:0]              perf_stall
`endif
);

    state_t            state, state_nx;
    logic [IW-1:0]     g, g_nx;
    logic [IW-1:0]     ptr, ptr_nx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [IW-1:0]     gnt_idx;
    bf16_t             sh_out;

    res_entry_t        mem [FIFO_DEPTH];
    res_entry_t        head;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, empty, xfer, pop;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx)
    );

    rshift u_rshift (
        .a     (req_data[g]),
        .shift (req_shift[g]),
        .y     (sh_out)
    );

    assign full  = count == (AW+1)'(FIFO_DEPTH);
    assign empty = count == '0;
    assign head  = mem[rd_ptr];
    assign xfer  = state == BURST && req_valid[g] && req_ready[g];
    assign pop   = !empty && res_ready;

    // Only the lock holder may push; a full FIFO accepts if it drains
    always_comb begin
        req_ready = '0;
        if (state == BURST) req_ready[g] = !full || res_ready;
    end

    // Grant in IDLE, hold lock until the last element transfers
    always_comb begin
        state_nx = state;
        g_nx     = g;
        ptr_nx   = ptr;
        unique case (state)
            IDLE: begin
                if (|gnt_oh) begin
                    g_nx     = gnt_idx;
                    state_nx = BURST;
                end
            end
            BURST: begin
                if (xfer && req_last[g]) begin
                    state_nx = IDLE;
                    ptr_nx   = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM, grant and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            g     <= g_nx;
            ptr   <= ptr_nx;
        end
    end

    // Result storage; contents are masked at the output while empty
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wr_ptr] <= '{data: sh_out, id: ID_W'(g), last: req_last[g]};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (xfer) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(xfer) - (AW+1)'(pop);
        end
    end

    assign res_valid = !empty;
    assign res_data  = empty ? 16'h0000 : head.data;
    assign res_id    = empty ? '0 : IW'(head.id);
    assign res_last  = !empty && head.last;
    assign busy      = state != IDLE || !empty;

`ifdef SHIFT_ARBITER_PERF_EN
    // Free-running transfer and output-stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_elems <= '0;
            perf_stall <= '0;
        end else begin
            perf_elems <= perf_elems + 32'(xfer);
            perf_stall <= perf_stall + 32'(res_valid && !res_ready);
        end
    end
`endif

endmodule
